mfp_ahb_7sd_scanner: RTL
========================

MFP_AHB_7SD_SCANNER -- requirements
Module: mfp_ahb_7sd_scanner

Interface
REQ-001 Parameter DIGIT_CYCLES, default 4096: clock cycles each digit is driven; legal range 1 to 2^20.
REQ-002 Parameter BLANK_CYCLES, default 16: all-off dead-time cycles before each digit; legal range 0 to 2^20.
REQ-003 The block SHALL use one clock, with a synchronous active-high reset.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 load  in  1  single-cycle strobe; captures codes_in, dp_in and en_in into the pending buffer.
REQ-007 codes_in  in  40  digit i display code at bits [5i+4:5i], i = 0..7; code values follow the team's 0-31 decoder code map.
REQ-008 dp_in  in  8  per-digit decimal point; active low.
REQ-009 en_in  in  8  per-digit enable; 1 = lit.
REQ-010 anode  out  8  digit select; active low, at most one bit low at any time.
REQ-011 data  out  6  {dp, code[4:0]} for the downstream decoder; dp bit is active low.
REQ-012 frame_done  out  1  one-cycle pulse on the last DRIVE cycle of digit 7.
REQ-013 pend_valid  out  1  1 = pending buffer holds a frame not yet shown.

Function
REQ-014 The block SHALL hold two register sets, pending and active, each containing codes (40b), dp (8b) and en (8b).
REQ-015 FSM states SHALL be BLANK and DRIVE, with a digit index idx in 0..7 and a cycle counter cnt.
REQ-016 In BLANK, anode SHALL be 8'hFF and data SHALL be 6'h3F (dp off, code 31 = blank), for BLANK_CYCLES cycles; the FSM then enters DRIVE with cnt = 0.
REQ-017 If BLANK_CYCLES = 0, BLANK SHALL be skipped and DRIVE follows DRIVE directly.
REQ-018 In DRIVE, data SHALL be {active.dp[idx], active.codes[idx]} for DIGIT_CYCLES cycles.
REQ-019 In DRIVE, anode SHALL be ~(8'h01 << idx) if active.en[idx] = 1, else 8'hFF.
REQ-020 At the end of DRIVE, idx SHALL increment modulo 8 and the FSM SHALL enter BLANK (or DRIVE per REQ-017).
REQ-021 anode and data SHALL be registered and change on the same clock edge; no combinational path from inputs to outputs.
REQ-022 Frame period SHALL be exactly 8*(DIGIT_CYCLES+BLANK_CYCLES) cycles.
REQ-023 load SHALL write the pending set and set pend_valid on the next edge, regardless of FSM state.
REQ-024 Frame boundary = the edge ending the last DRIVE cycle of idx 7; frame_done SHALL be 1 during that cycle.
REQ-025 At a frame boundary with pend_valid = 1, active SHALL take pending and pend_valid SHALL clear; with pend_valid = 0, active is unchanged.
REQ-026 load coincident with a boundary: active SHALL take the old pending contents, pending SHALL take the new inputs, and pend_valid SHALL stay 1.
REQ-027 Multiple loads within one frame: the last load SHALL win; earlier loads are discarded silently.
REQ-028 active SHALL never change except at a frame boundary, so no tearing within a frame.
REQ-029 cnt SHALL be sized to hold max(DIGIT_CYCLES, BLANK_CYCLES) - 1 and SHALL never wrap outside its terminal-count compare.

Reset
REQ-030 While reset = 1, state SHALL be BLANK, idx = 0, cnt = 0, anode = 8'hFF, data = 6'h3F, frame_done = 0, pend_valid = 0.
REQ-031 While reset = 1, active and pending codes SHALL be all 5'd31, dp = 8'hFF, and en = 8'h00.
REQ-032 Reset asserted mid-DRIVE or mid-frame SHALL take effect on the next edge, discarding any pending frame; load is ignored while reset = 1.
REQ-033 After reset release, the first BLANK of idx 0 SHALL begin at cycle 0.

Verification (DIGIT_CYCLES = 4, BLANK_CYCLES = 2; cycle 0 = first cycle after reset release)
REQ-034 Reset: hold reset 3 cycles, then release -> anode = FF, data = 3F, frame_done = 0, pend_valid = 0; cycles 2-5 anode stays FF (en = 0).
REQ-035 Load then display: at cycle 5 pulse load with codes i -> digit i, en = FF, dp = FF.
  Required: pend_valid = 1 at cycle 6; frame_done = 1 only at cycle 47; pend_valid = 0 at cycle 48.
  Cycles 48-49: anode FF, data 3F. Cycles 50-53: anode FE, data 20. Cycles 56-59: anode FD, data 21.
REQ-036 Disabled digit with dp: en = 8'b11111011, dp = 8'b11111110, loaded and transferred.
  Required: digit 0 drive shows data = 6'h00; digit 2 slot shows anode FF for all 6 cycles.
REQ-037 Boundary collision: load A at cycle 20; load B at cycle 47.
  Required: the frame starting at cycle 48 shows A; pend_valid stays 1; the frame starting at cycle 96 shows B; pend_valid = 0 at cycle 96.
REQ-038 Mid-operation reset: with codes displayed, assert reset at cycle 51 (digit 0 DRIVE) for 1 cycle.
  Required: next cycle anode = FF, data = 3F; after release, displayed digits are blank until a new load plus a boundary.
REQ-039 BLANK_CYCLES = 0: frame period = 32 cycles; anode goes FE -> FD at the DRIVE-to-DRIVE transition with no FF cycle between (en = FF).

Source files
------------

// File: rtl/mfp_ahb_7sd_scanner.sv
// rtl/mfp_ahb_7sd_scanner.sv - eight-digit seven-segment scanner with double-buffered frames
module mfp_ahb_7sd_scanner #(
    parameter int DIGIT_CYCLES = 4096,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [39:0] codes_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  en_in,
    output logic [7:0]  anode,
    output logic [5:0]  data,
    output logic        frame_done,
    output logic        pend_valid
);

    localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] D_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] B_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;
    // With no dead time the scan starts directly in DRIVE; outputs still come up dark
    // because the active set resets with every digit disabled.
    localparam logic [0:0] ST_RESET = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

    localparam logic [39:0] CODES_OFF = {8{5'd31}};

    logic [0:0]    state, state_n;
    logic [2:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;

    logic [39:0] act_codes, act_codes_n, pend_codes;
    logic [7:0]  act_dp, act_dp_n, pend_dp;
    logic [7:0]  act_en, act_en_n, pend_en;

    logic        boundary;
    logic [5:0]  base;
    logic [7:0]  anode_n;
    logic [5:0]  data_n;
    logic        frame_done_n;

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        boundary = (state == ST_DRIVE) && (idx == 3'd7) && (cnt == D_LAST);

        if (state == ST_BLANK) begin
            if (cnt == B_LAST) begin
                state_n = ST_DRIVE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end else begin
            if (cnt == D_LAST) begin
                idx_n   = idx + 3'd1;
                cnt_n   = '0;
                state_n = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;
            end else begin
                cnt_n = cnt + CW'(1);
            end
        end

        if (boundary && pend_valid) begin
            act_codes_n = pend_codes;
            act_dp_n    = pend_dp;
            act_en_n    = pend_en;
        end else begin
            act_codes_n = act_codes;
            act_dp_n    = act_dp;
            act_en_n    = act_en;
        end

        // Outputs are registered from the next state so they move on the same edge as it.
        base = 6'(idx_n) * 6'd5;
        if (state_n == ST_DRIVE) begin
            anode_n = act_en_n[idx_n] ? ~(8'h01 << idx_n) : 8'hFF;
            data_n  = {act_dp_n[idx_n], act_codes_n[base +: 5]};
        end else begin
            anode_n = 8'hFF;
            data_n  = 6'h3F;
        end
        frame_done_n = (state_n == ST_DRIVE) && (idx_n == 3'd7) && (cnt_n == D_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RESET;
            idx        <= '0;
            cnt        <= '0;
            act_codes  <= CODES_OFF;
            act_dp     <= 8'hFF;
            act_en     <= 8'h00;
            pend_codes <= CODES_OFF;
            pend_dp    <= 8'hFF;
            pend_en    <= 8'h00;
            pend_valid <= 1'b0;
            anode      <= 8'hFF;
            data       <= 6'h3F;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            act_codes  <= act_codes_n;
            act_dp     <= act_dp_n;
            act_en     <= act_en_n;
            if (load) begin
                pend_codes <= codes_in;
                pend_dp    <= dp_in;
                pend_en    <= en_in;
            end
            // A load on the boundary edge refills pending as the old contents move to active.
            pend_valid <= load | (pend_valid & ~boundary);
            anode      <= anode_n;
            data       <= data_n;
            frame_done <= frame_done_n;
        end
    end

endmodule
